motor_arm_sequencer: RTL and testbench
======================================

# motor_arm_sequencer

Arming, spin-up and failsafe controller placed between the four motor offset summers and the four PWM generators. It decodes the throttle and arm-switch receiver values into an arm/disarm state machine, ramps the motor command ceiling after arming, and forces a defined motor command when receiver updates stop. It gates the existing motor datapath and does not change it.

## Interface
- CLK_HZ, 38_000_000: clk frequency; 1 ms tick period = CLK_HZ/1000 cycles.
- ARM_HOLD_MS, 500: arm condition hold time.
- RX_TIMEOUT_MS, 100: maximum gap between rx_strobe pulses before failsafe.
- FS_HOLD_MS, 2000: failsafe descent hold time.
- FS_VAL, 11'd300: motor command during failsafe hold.
- RAMP_STEP, 11'd4: ceiling increment per ms in SPINUP.
- THR_LOW, 10'd50: throttle must be strictly below this to arm.
- SW_ON / SW_OFF, 10'd700 / 10'd300: arm switch thresholds (hysteresis).
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- rx_strobe  in  1  one-cycle pulse on any receiver channel update.
- throttle_val  in  10  throttle receiver reading.
- switch_val  in  10  arm switch receiver reading.
- m1_in..m4_in  in  11 each  summed motor commands.
- m1_out..m4_out  out  11 each  gated commands to the pwm generators.
- armed  out  1  high in SPINUP and ARMED.
- state  out  3  current state encoding.

## Operation
- States/encoding: DISARMED=0, ARM_WAIT=1, SPINUP=2, ARMED=3, FAILSAFE=4, LOCKOUT=5. Codes 6-7 go to DISARMED on the next clock.
- sw_on register: set when switch_val >= SW_ON, cleared when switch_val <= SW_OFF, otherwise held. Reset value 0.
- rx_lost: a ms counter cleared by rx_strobe and saturating at RX_TIMEOUT_MS. rx_lost = (count == RX_TIMEOUT_MS). After reset the counter is saturated, so rx_lost = 1 until the first strobe.
- DISARMED: outputs 0. Go to ARM_WAIT when sw_on, throttle_val < THR_LOW and !rx_lost.
- ARM_WAIT: outputs 0. If any condition drops, go to DISARMED. After ARM_HOLD_MS consecutive ticks, go to SPINUP with ceiling = 0.
- SPINUP: out = min(m_in, ceiling) per motor. Ceiling += RAMP_STEP each tick, saturating at 11'h7FF. Go to ARMED when ceiling reaches 11'h7FF.
- ARMED: out = m_in.
- From SPINUP or ARMED:
  - rx_lost goes to FAILSAFE. It has priority over the switch.
  - !sw_on goes to DISARMED.
- FAILSAFE: out = min(m_in, FS_VAL) per motor. After FS_HOLD_MS ticks go to LOCKOUT. rx_strobe does not exit this state.
- LOCKOUT: outputs 0. Go to DISARMED only when !sw_on and !rx_lost.
- The ms prescaler free-runs from reset. Hold and ramp counters clear on every state entry.

## Timing
- Reset values:
  - all m*_out = 0, armed = 0, state = 0
  - prescaler = 0, ceiling = 0
- All outputs are registered. m_in to m_out latency is 1 cycle.
- State changes take effect on the clock after the condition is sampled. Outputs reflect the new state one cycle later (registered gating).
- Hold and timeout resolution is ±1 ms, set by the free-running tick.
- rx_strobe and a tick in the same cycle: the strobe wins and the counter goes to 0.
- Asserting resetn mid-operation zeroes outputs immediately (asynchronous) and returns to DISARMED.

## Configuration
- MOTOR_SPINUP_EN defined: SPINUP ramp as above.
- MOTOR_SPINUP_EN undefined:
  - ARM_WAIT goes directly to ARMED.
  - SPINUP state and ceiling logic are not built.
  - Code 2 is treated as illegal and goes to DISARMED.

## Test plan
Test parameters: CLK_HZ=10_000 (tick every 10 cycles), ARM_HOLD_MS=5, RX_TIMEOUT_MS=4, FS_HOLD_MS=6, RAMP_STEP=512. rx_strobe every 20 cycles unless stated.
- Arm: switch_val=800, throttle_val=10 held for 5 ms. Required: state 0→1→2, armed=1. With m_in=1000, out steps 0, 512, 1000 (clamped to m_in), then state=3 and out=1000.
- Abort: drop throttle_val to 60 during ARM_WAIT. Required: return to state 0, outputs remain 0.
- Hysteresis: switch_val=500 after arming. Required: stays ARMED. switch_val=200 → DISARMED and out=0 one cycle later.
- Signal loss: stop rx_strobe while ARMED with m_in=1500. Required: FAILSAFE within 4-5 ms, out=300; after 6 ms LOCKOUT, out=0. Resumed strobes with sw_on still set keep LOCKOUT; switch_val=200 → DISARMED.
- Reset: assert resetn low while ARMED with m_in=1500. Required: all outputs 0 asynchronously; after release, state=0 and rx_lost=1 until the first strobe.
- Build without MOTOR_SPINUP_EN: arm sequence goes 0→1→3 with out=m_in immediately.

Source files
------------

// File: rtl/motor_arm_sequencer.sv
// Arm / spin-up / failsafe gate between the motor summers and the PWM generators.
// Define MOTOR_SPINUP_EN to build the SPINUP ceiling ramp; otherwise arming goes straight to ARMED.
module motor_arm_sequencer #(
  parameter int unsigned CLK_HZ        = 38_000_000,
  parameter int unsigned ARM_HOLD_MS   = 500,
  parameter int unsigned RX_TIMEOUT_MS = 100,
  parameter int unsigned FS_HOLD_MS    = 2000,
  parameter logic [10:0] FS_VAL        = 11'd300,
  parameter logic [10:0] RAMP_STEP     = 11'd4,
  parameter logic [9:0]  THR_LOW       = 10'd50,
  parameter logic [9:0]  SW_ON         = 10'd700,
  parameter logic [9:0]  SW_OFF        = 10'd300
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_strobe,
  input  logic [9:0]  throttle_val,
  input  logic [9:0]  switch_val,
  input  logic [10:0] m1_in,
  input  logic [10:0] m2_in,
  input  logic [10:0] m3_in,
  input  logic [10:0] m4_in,
  output logic [10:0] m1_out,
  output logic [10:0] m2_out,
  output logic [10:0] m3_out,
  output logic [10:0] m4_out,
  output logic        armed,
  output logic [2:0]  state
);

  localparam int unsigned TICK_DIV =
    (CLK_HZ >= 1000) ? CLK_HZ / 1000 : 1;
  localparam int unsigned PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HOLD_MAX =
    (ARM_HOLD_MS > FS_HOLD_MS) ? ARM_HOLD_MS : FS_HOLD_MS;
  localparam int unsigned HW = $clog2(HOLD_MAX + 1);
  localparam int unsigned RW = $clog2(RX_TIMEOUT_MS + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] RX_SAT   = RW'(RX_TIMEOUT_MS);
  localparam logic [HW-1:0] ARM_LAST = HW'(ARM_HOLD_MS - 1);
  localparam logic [HW-1:0] FS_LAST  = HW'(FS_HOLD_MS - 1);

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_ARM_WAIT = 3'd1,
    ST_SPINUP   = 3'd2,
    ST_ARMED    = 3'd3,
    ST_FAILSAFE = 3'd4,
    ST_LOCKOUT  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [PW-1:0] presc_q;
  logic [RW-1:0] rx_cnt_q;
  logic          sw_on_q;
  logic          armed_q;
  logic          tick, rx_lost, arm_ok;
  logic [10:0]   m_in   [4];
  logic [10:0]   m_gate [4];
  logic [10:0]   m_out_q[4];

  function automatic logic [10:0] min11(
    input logic [10:0] a,
    input logic [10:0] b
  );
    return (a < b) ? a : b;
  endfunction

  assign m_in[0] = m1_in;
  assign m_in[1] = m2_in;
  assign m_in[2] = m3_in;
  assign m_in[3] = m4_in;

  assign tick    = (presc_q == PRE_LAST);
  assign rx_lost = (rx_cnt_q == RX_SAT);
  assign arm_ok  = sw_on_q && (throttle_val < THR_LOW) && !rx_lost;

`ifdef MOTOR_SPINUP_EN
  logic [10:0] ceil_q, ceil_d;
  logic [11:0] ceil_sum;

  assign ceil_sum = {1'b0, ceil_q} + {1'b0, RAMP_STEP};
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q  <= '0;
      rx_cnt_q <= RX_SAT;
      sw_on_q  <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      // a strobe in the same cycle as a tick still restarts the timeout
      if (rx_strobe) begin
        rx_cnt_q <= '0;
      end else if (tick && !rx_lost) begin
        rx_cnt_q <= rx_cnt_q + RW'(1);
      end
      if (switch_val >= SW_ON) begin
        sw_on_q <= 1'b1;
      end else if (switch_val <= SW_OFF) begin
        sw_on_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
`ifdef MOTOR_SPINUP_EN
    ceil_d  = ceil_q;
`endif
    unique case (state_q)
      ST_DISARMED: begin
        if (arm_ok) state_d = ST_ARM_WAIT;
      end
      ST_ARM_WAIT: begin
        if (!arm_ok) begin
          state_d = ST_DISARMED;
        end else if (tick) begin
          hold_d = hold_q + HW'(1);
          if (hold_q == ARM_LAST) begin
`ifdef MOTOR_SPINUP_EN
            state_d = ST_SPINUP;
`else
            state_d = ST_ARMED;
`endif
          end
        end
      end
`ifdef MOTOR_SPINUP_EN
      ST_SPINUP: begin
        if (rx_lost) begin
          state_d = ST_FAILSAFE;
        end else if (!sw_on_q) begin
          state_d = ST_DISARMED;
        end else if (ceil_q == 11'h7FF) begin
          state_d = ST_ARMED;
        end else if (tick) begin
          ceil_d = ceil_sum[11] ? 11'h7FF : ceil_sum[10:0];
        end
      end
`endif
      ST_ARMED: begin
        if (rx_lost) begin
          state_d = ST_FAILSAFE;
        end else if (!sw_on_q) begin
          state_d = ST_DISARMED;
        end
      end
      ST_FAILSAFE: begin
        if (tick) begin
          hold_d = hold_q + HW'(1);
          if (hold_q == FS_LAST) state_d = ST_LOCKOUT;
        end
      end
      ST_LOCKOUT: begin
        if (!sw_on_q && !rx_lost) state_d = ST_DISARMED;
      end
      default: state_d = ST_DISARMED;
    endcase
    if (state_d != state_q) begin
      hold_d = '0;
`ifdef MOTOR_SPINUP_EN
      ceil_d = '0;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      m_gate[i] = '0;
      unique case (state_q)
        ST_ARMED:    m_gate[i] = m_in[i];
        ST_FAILSAFE: m_gate[i] = min11(m_in[i], FS_VAL);
`ifdef MOTOR_SPINUP_EN
        ST_SPINUP:   m_gate[i] = min11(m_in[i], ceil_q);
`endif
        default:     m_gate[i] = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_DISARMED;
      hold_q  <= '0;
      armed_q <= 1'b0;
      for (int i = 0; i < 4; i++) m_out_q[i] <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      armed_q <= (state_d == ST_SPINUP) || (state_d == ST_ARMED);
      for (int i = 0; i < 4; i++) m_out_q[i] <= m_gate[i];
    end
  end

`ifdef MOTOR_SPINUP_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ceil_q <= '0;
    end else begin
      ceil_q <= ceil_d;
    end
  end
`endif

  assign m1_out = m_out_q[0];
  assign m2_out = m_out_q[1];
  assign m3_out = m_out_q[2];
  assign m4_out = m_out_q[3];
  assign armed  = armed_q;
  assign state  = state_q;

endmodule

// File: tb/tb_motor_arm_sequencer.sv
// Bench for motor_arm_sequencer: directed arm/abort/loss/reset scenarios
// plus random stimulus, all checked every cycle against a behavioural model.
module tb_motor_arm_sequencer;

  localparam int DIV  = 10;
  localparam int HOLD = 5;
  localparam int TO   = 4;
  localparam int FSH  = 6;
  localparam int STEP = 512;
  localparam int FSV  = 300;
  localparam int RXP  = 20;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_strobe = 1'b0;
  logic [9:0]  throttle_val = '0;
  logic [9:0]  switch_val = '0;
  logic [10:0] mi [4];
  logic [10:0] m1_out, m2_out, m3_out, m4_out;
  logic        armed;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit rx_auto = 1'b0;
  int scnt = 0;

  // model: time in cycles/ms, state as an int code
  int mcyc, mrx, mst, mticks, mceil, msw;
  int eo [4];
  int est, earm;

  int seq_q[$];
  int outv_q[$];
  int exp_seq[$];
  int exp_out[$];

  always #5 clk = ~clk;

  motor_arm_sequencer #(
    .CLK_HZ(10_000),
    .ARM_HOLD_MS(HOLD),
    .RX_TIMEOUT_MS(TO),
    .FS_HOLD_MS(FSH),
    .FS_VAL(11'd300),
    .RAMP_STEP(11'd512),
    .THR_LOW(10'd50),
    .SW_ON(10'd700),
    .SW_OFF(10'd300)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rx_strobe(rx_strobe),
    .throttle_val(throttle_val),
    .switch_val(switch_val),
    .m1_in(mi[0]),
    .m2_in(mi[1]),
    .m3_in(mi[2]),
    .m4_in(mi[3]),
    .m1_out(m1_out),
    .m2_out(m2_out),
    .m3_out(m3_out),
    .m4_out(m4_out),
    .armed(armed),
    .state(state)
  );

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d, required %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int gate(input int st, input int m, input int c);
    case (st)
      3: return m;
      4: return imin(m, FSV);
`ifdef MOTOR_SPINUP_EN
      2: return imin(m, c);
`endif
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    mcyc = 0; mrx = TO; mst = 0; mticks = 0; mceil = 0; msw = 0;
    est = 0; earm = 0;
    for (int i = 0; i < 4; i++) eo[i] = 0;
  endtask

  task automatic model_step();
    bit tk, lost, ok;
    int nst, sv;
    tk = ((mcyc % DIV) == DIV - 1);
    mcyc++;
    lost = (mrx >= TO);
    ok = (msw != 0) && (int'(throttle_val) < 50) && !lost;
    for (int i = 0; i < 4; i++) eo[i] = gate(mst, int'(mi[i]), mceil);
    nst = mst;
    case (mst)
      0: if (ok) nst = 1;
      1: begin
        if (!ok) nst = 0;
        else if (tk) begin
          mticks++;
`ifdef MOTOR_SPINUP_EN
          if (mticks == HOLD) nst = 2;
`else
          if (mticks == HOLD) nst = 3;
`endif
        end
      end
      2: begin
        if (lost) nst = 4;
        else if (msw == 0) nst = 0;
        else if (mceil == 2047) nst = 3;
        else if (tk) mceil = imin(mceil + STEP, 2047);
      end
      3: begin
        if (lost) nst = 4;
        else if (msw == 0) nst = 0;
      end
      4: if (tk) begin
        mticks++;
        if (mticks == FSH) nst = 5;
      end
      5: if (msw == 0 && !lost) nst = 0;
      default: nst = 0;
    endcase
    if (nst != mst) begin
      mticks = 0;
      mceil = 0;
    end
    mst = nst;
    est = nst;
    earm = (nst == 2 || nst == 3) ? 1 : 0;
    if (rx_strobe) mrx = 0;
    else if (tk) mrx = imin(mrx + 1, TO);
    sv = int'(switch_val);
    if (sv >= 700) msw = 1;
    else if (sv <= 300) msw = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_state", int'(state), est);
      check("cmp_armed", int'(armed), earm);
      check("cmp_m1", int'(m1_out), eo[0]);
      check("cmp_m2", int'(m2_out), eo[1]);
      check("cmp_m3", int'(m3_out), eo[2]);
      check("cmp_m4", int'(m4_out), eo[3]);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (!resetn) model_reset();
    else model_step();
    #1;
    if (rx_auto) begin
      rx_strobe = (scnt == 0);
      scnt = (scnt + 1) % RXP;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_rx();
    rx_auto = 1'b1;
    rx_strobe = 1'b1;
    scnt = 1;
  endtask

  task automatic stop_rx();
    rx_auto = 1'b0;
    rx_strobe = 1'b0;
  endtask

  task automatic set_m(input int v);
    for (int i = 0; i < 4; i++) mi[i] = 11'(v);
  endtask

  task automatic wait_state(input int tgt, input int budget,
                            input string nm, output int n);
    n = 0;
    while (int'(state) != tgt && n < budget) begin
      tick();
      n++;
    end
    check(nm, int'(state), tgt);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, n2;
    int sw_tab[10];
    int thr_tab[7];
    sw_tab  = '{800, 800, 800, 200, 500, 700, 699, 300, 301, 0};
    thr_tab = '{10, 10, 10, 49, 50, 60, 0};
`ifdef MOTOR_SPINUP_EN
    exp_seq = '{0, 1, 2, 3};
    exp_out = '{0, 512, 1000};
`else
    exp_seq = '{0, 1, 3};
    exp_out = '{0, 1000};
`endif
    set_m(0);
    model_reset();
    tick();
    chk_en = 1'b1;
    ticks(2);
    check("rst_state", int'(state), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_m1", int'(m1_out), 0);
    resetn = 1'b1;

    // no strobe yet: rx_lost blocks arming
    switch_val = 10'd800;
    throttle_val = 10'd10;
    set_m(1000);
    ticks(30);
    check("no_strobe_disarmed", int'(state), 0);

    // arm sequence
    start_rx();
    seq_q.delete();
    outv_q.delete();
    seq_q.push_back(int'(state));
    outv_q.push_back(int'(m1_out));
    n = 0;
    while (int'(state) != 3 && n < 300) begin
      tick();
      n++;
      if (int'(state) != seq_q[$]) seq_q.push_back(int'(state));
      if (int'(m1_out) != outv_q[$]) outv_q.push_back(int'(m1_out));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (int'(m1_out) != outv_q[$]) outv_q.push_back(int'(m1_out));
    end
    check("arm_reached", int'(state), 3);
    check("arm_armed", int'(armed), 1);
    check("arm_out", int'(m1_out), 1000);
    check("arm_seq_len", seq_q.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < seq_q.size(); i++)
      check("arm_seq", seq_q[i], exp_seq[i]);
    check("arm_outs_len", outv_q.size(), exp_out.size());
    for (int i = 0; i < exp_out.size() && i < outv_q.size(); i++)
      check("arm_outs", outv_q[i], exp_out[i]);

    // hysteresis
    switch_val = 10'd500;
    ticks(30);
    check("hyst_hold", int'(state), 3);
    switch_val = 10'd200;
    ticks(3);
    check("hyst_off_state", int'(state), 0);
    check("hyst_off_out", int'(m1_out), 0);

    // abort during ARM_WAIT
    switch_val = 10'd800;
    wait_state(1, 50, "abort_wait", n);
    throttle_val = 10'd60;
    ticks(2);
    check("abort_state", int'(state), 0);
    check("abort_out", int'(m1_out), 0);
    throttle_val = 10'd10;
    wait_state(3, 300, "rearm1", n);

    // signal loss
    set_m(1500);
    ticks(2);
    rx_auto = 1'b0;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
    wait_state(4, 80, "loss_fs", n);
    check("loss_latency", int'(n >= 31 && n <= 42), 1);
    start_rx();
    ticks(2);
    check("fs_out1", int'(m1_out), FSV);
    check("fs_out4", int'(m4_out), FSV);
    wait_state(5, 100, "fs_lockout", n2);
    check("fs_hold_len", int'((n2 + 2) >= 50 && (n2 + 2) <= 61), 1);
    ticks(2);
    check("lock_out", int'(m1_out), 0);
    ticks(40);
    check("lock_hold", int'(state), 5);
    switch_val = 10'd200;
    ticks(4);
    check("lock_exit", int'(state), 0);

    // async reset while armed
    switch_val = 10'd800;
    wait_state(3, 300, "rearm2", n);
    ticks(3);
    #1;
    resetn = 1'b0;
    model_reset();
    #1;
    check("areset_m1", int'(m1_out), 0);
    check("areset_m2", int'(m2_out), 0);
    check("areset_m3", int'(m3_out), 0);
    check("areset_m4", int'(m4_out), 0);
    check("areset_state", int'(state), 0);
    check("areset_armed", int'(armed), 0);
    stop_rx();
    ticks(3);
    resetn = 1'b1;
    ticks(30);
    check("post_rst_rxlost", int'(state), 0);
    start_rx();
    wait_state(1, 10, "post_rst_arm", n);

    // random stimulus
    for (int s = 0; s < 40; s++) begin
      int len, mode, v;
      len = $urandom_range(150, 20);
      mode = $urandom_range(2, 0);
      v = sw_tab[$urandom_range(9, 0)];
      switch_val = (v == 0) ? 10'($urandom_range(1023, 0)) : 10'(v);
      v = thr_tab[$urandom_range(6, 0)];
      throttle_val = (v == 0) ? 10'($urandom_range(1023, 0)) : 10'(v);
      if ($urandom_range(15, 0) == 0) begin
        resetn = 1'b0;
        model_reset();
        ticks(2);
        resetn = 1'b1;
      end
      if (mode == 1) start_rx();
      else stop_rx();
      for (int c = 0; c < len; c++) begin
        for (int i = 0; i < 4; i++) mi[i] = 11'($urandom_range(2047, 0));
        if (mode == 2) rx_strobe = ($urandom_range(5, 0) == 0);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
